// File: rtl/sys_array_sched.sv
// sys_array_sched: job sequencer for the aligned systolic array.
// Accepts one tile job per start pulse and streams K operand vectors from the
// A/B buffers into a diagonal skew. It then waits for the array to drain and
// flags when the result bus holds the finished tile.

// Per-lane delay line: lane n is delayed by n register stages.
module sys_array_skew #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] din,
    output logic [LANES*WIDTH-1:0] dout
);
    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        if (g == 0) begin : g_pass
            assign dout[WIDTH-1:0] = din[WIDTH-1:0];
        end else begin : g_dly
            logic [WIDTH-1:0] stg [g];

            // shift lane g through its g stages; reset flushes the diagonal
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned s = 0; s < g; s++) stg[s] <= '0;
                end else begin
                    stg[0] <= din[g*WIDTH +: WIDTH];
                    for (int unsigned s = 1; s < g; s++) stg[s] <= stg[s-1];
                end
            end

            assign dout[g*WIDTH +: WIDTH] = stg[g-1];
        end
    end
endmodule

module sys_array_sched #(
    parameter int ROWS      = 4,
    parameter int COLS      = 256,
    parameter int WIDTH     = 16,
    parameter int K_W       = 8,
    parameter int ADDR_W    = 10,
    parameter int DRAIN_PAD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    input  logic [ADDR_W-1:0]     a_base,
    input  logic [ADDR_W-1:0]     b_base,
    input  logic [1:0]            simd_mode,
    input  logic [ROWS*WIDTH-1:0] a_rd_data,
    input  logic [COLS*WIDTH-1:0] b_rd_data,
    output logic                  a_rd_en,
    output logic                  b_rd_en,
    output logic [ADDR_W-1:0]     a_rd_addr,
    output logic [ADDR_W-1:0]     b_rd_addr,
    output logic [ROWS*WIDTH-1:0] arr_in_a,
    output logic [COLS*WIDTH-1:0] arr_in_b,
    output logic [1:0]            SIMD_Control,
    output logic                  arr_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  c_valid
);
    localparam int DRAIN_LEN = ROWS + COLS + DRAIN_PAD;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
    localparam int CNT_W     = (K_W > DRAIN_W) ? K_W : DRAIN_W;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      cnt;
    logic [K_W-1:0]        k_q;
    logic [ADDR_W-1:0]     a_addr_q, b_addr_q;
    logic                  rd_vld;
    logic [CNT_W-1:0]      k_last;
    logic [ROWS*WIDTH-1:0] a_gated;
    logic [COLS*WIDTH-1:0] b_gated;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // next-state decode and per-state strobes
    always_comb begin
        next_state = state;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        a_rd_addr  = '0;
        b_rd_addr  = '0;
        arr_clear  = 1'b0;
        done       = 1'b0;
        c_valid    = 1'b0;
        busy       = 1'b1;
        k_last     = CNT_W'(k_q) - CNT_W'(1);
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) next_state = S_CLEAR;
            end
            S_CLEAR: begin
                arr_clear  = 1'b1;
                next_state = (k_q != '0) ? S_FEED : S_DONE;
            end
            S_FEED: begin
                a_rd_en   = 1'b1;
                b_rd_en   = 1'b1;
                a_rd_addr = a_addr_q;
                b_rd_addr = b_addr_q;
                if (cnt == k_last) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(DRAIN_LEN - 1)) next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                c_valid    = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // phase counter, restarted on every state change and held at 0 in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     cnt <= '0;
        else if (state != next_state || state == S_IDLE) cnt <= '0;
        else                                            cnt <= cnt + CNT_W'(1);
    end

    // job parameters latched on accept; addresses step (and wrap) through FEED
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q          <= '0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            SIMD_Control <= '0;
        end else if (state == S_IDLE && start) begin
            k_q          <= k_len;
            a_addr_q     <= a_base;
            b_addr_q     <= b_base;
            SIMD_Control <= simd_mode;
        end else if (state == S_FEED) begin
            a_addr_q <= a_addr_q + ADDR_W'(1);
            b_addr_q <= b_addr_q + ADDR_W'(1);
        end
    end

    // read data is valid the cycle after a strobe (A and B strobe together)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_vld <= 1'b0;
        else        rd_vld <= a_rd_en;
    end

    assign a_gated = rd_vld ? a_rd_data : '0;
    assign b_gated = rd_vld ? b_rd_data : '0;

    sys_array_skew #(.LANES(ROWS), .WIDTH(WIDTH)) u_skew_a (
        .clk   (clk),
        .reset (reset),
        .din   (a_gated),
        .dout  (arr_in_a)
    );

    sys_array_skew #(.LANES(COLS), .WIDTH(WIDTH)) u_skew_b (
        .clk   (clk),
        .reset (reset),
        .din   (b_gated),
        .dout  (arr_in_b)
    );
endmodule

// File: tb/tb_sys_array_sched.sv
// Scoreboard bench for sys_array_sched: a 2x2 instance for timing/skew/boundary
// jobs and a 4x4 instance driving a behavioural array for the identity tile.
module tb_sys_array_sched;
    localparam int W = 16;

    typedef struct { int cyc; int v0; int v1; } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 2x2 instance ----------------
    logic        start;
    logic [7:0]  k_len;
    logic [9:0]  a_base, b_base;
    logic [1:0]  simd_mode;
    logic [31:0] a_rd_data, b_rd_data;
    logic        a_rd_en, b_rd_en;
    logic [9:0]  a_rd_addr, b_rd_addr;
    logic [31:0] arr_in_a, arr_in_b;
    logic [1:0]  SIMD_Control;
    logic        arr_clear, busy, done, c_valid;

    sys_array_sched #(.ROWS(2), .COLS(2), .WIDTH(16), .K_W(8), .ADDR_W(10), .DRAIN_PAD(2)) u_dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .a_base(a_base), .b_base(b_base),
        .simd_mode(simd_mode), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
        .arr_in_a(arr_in_a), .arr_in_b(arr_in_b), .SIMD_Control(SIMD_Control),
        .arr_clear(arr_clear), .busy(busy), .done(done), .c_valid(c_valid)
    );

    // ---------------- 4x4 instance ----------------
    logic        start4;
    logic [7:0]  k_len4;
    logic [9:0]  a_base4, b_base4;
    logic [1:0]  simd_mode4;
    logic [63:0] a_rd_data4, b_rd_data4;
    logic        a_rd_en4, b_rd_en4;
    logic [9:0]  a_rd_addr4, b_rd_addr4;
    logic [63:0] arr_in_a4, arr_in_b4;
    logic [1:0]  SIMD_Control4;
    logic        arr_clear4, busy4, done4, c_valid4;

    sys_array_sched #(.ROWS(4), .COLS(4), .WIDTH(16), .K_W(8), .ADDR_W(10), .DRAIN_PAD(2)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .k_len(k_len4), .a_base(a_base4), .b_base(b_base4),
        .simd_mode(simd_mode4), .a_rd_data(a_rd_data4), .b_rd_data(b_rd_data4),
        .a_rd_en(a_rd_en4), .b_rd_en(b_rd_en4), .a_rd_addr(a_rd_addr4), .b_rd_addr(b_rd_addr4),
        .arr_in_a(arr_in_a4), .arr_in_b(arr_in_b4), .SIMD_Control(SIMD_Control4),
        .arr_clear(arr_clear4), .busy(busy4), .done(done4), .c_valid(c_valid4)
    );

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // buffer contents: distinct, nonzero per address and lane
    function automatic logic [15:0] a_val(input int addr, input int n);
        return 16'(4096 * (n + 1) + addr);
    endfunction
    function automatic logic [15:0] b_val(input int addr, input int n);
        return 16'(16384 + 4096 * n + addr);
    endfunction

    // 2x2 buffers: one-cycle read latency, junk when not read
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            a_rd_data[n*W +: W] <= a_rd_en ? a_val(int'(a_rd_addr), n) : 16'hDEAD;
            b_rd_data[n*W +: W] <= b_rd_en ? b_val(int'(b_rd_addr), n) : 16'hBEEF;
        end
    end

    // 4x4 buffers: A is identity (row i at address i), B[i][c] = 16*(i+1)+c+1 at 20+i
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            a_rd_data4[n*W +: W] <= a_rd_en4 ? ((int'(a_rd_addr4) == n) ? 16'd1 : 16'd0) : 16'hDEAD;
            b_rd_data4[n*W +: W] <= b_rd_en4 ? 16'((int'(b_rd_addr4) - 20 + 1) * 16 + n + 1) : 16'hBEEF;
        end
    end

    // behavioural output-stationary 4x4 array fed by the skewed streams
    logic [15:0] pa [4][4];
    logic [15:0] pb [4][4];
    int          acc [4][4];
    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int ai, bi;
                ai = (c == 0) ? int'(arr_in_a4[r*W +: W]) : int'(pa[r][c-1]);
                bi = (r == 0) ? int'(arr_in_b4[c*W +: W]) : int'(pb[r-1][c]);
                pa[r][c]  <= 16'(ai);
                pb[r][c]  <= 16'(bi);
                acc[r][c] <= arr_clear4 ? 0 : acc[r][c] + ai * bi;
            end
        end
    end

    ev_t clr_q[$], addr_q[$], done_q[$], busy_q[$], cq[$];
    ev_t lq[4][$];

    // expected events of one 2x2 job accepted in cycle s
    task automatic push_exp(input int s, input int k, input int ab, input int bb, input int md);
        int d;
        clr_q.push_back(ev_t'{s + 1, 0, 0});
        for (int i = 0; i < k; i++) begin
            addr_q.push_back(ev_t'{s + 2 + i, (ab + i) % 1024, (bb + i) % 1024});
            for (int n = 0; n < 2; n++) begin
                lq[n].push_back(ev_t'{s + 3 + i + n, int'(a_val((ab + i) % 1024, n)), 0});
                lq[2 + n].push_back(ev_t'{s + 3 + i + n, int'(b_val((bb + i) % 1024, n)), 0});
            end
        end
        d = s + 2 + k + ((k != 0) ? 6 : 0);
        done_q.push_back(ev_t'{d, md, 0});
        busy_q.push_back(ev_t'{s + 1, d - s, 0});
    endtask

    // ---------------- monitor ----------------
    ev_t  e;
    logic busy_prev = 1'b0;
    int   bstart = 0;
    always @(negedge clk) begin
        if (arr_clear) begin
            chk("clear expected", int'(clr_q.size() > 0), 1);
            if (clr_q.size() > 0) begin
                e = clr_q.pop_front();
                chk("clear cycle", cyc, e.cyc);
            end
        end
        if (a_rd_en || b_rd_en) begin
            chk("read expected", int'(addr_q.size() > 0), 1);
            chk("strobes paired", int'(a_rd_en), int'(b_rd_en));
            if (addr_q.size() > 0) begin
                e = addr_q.pop_front();
                chk("read cycle", cyc, e.cyc);
                chk("a_rd_addr", int'(a_rd_addr), e.v0);
                chk("b_rd_addr", int'(b_rd_addr), e.v1);
            end
        end
        for (int n = 0; n < 4; n++) begin
            int v;
            v = (n < 2) ? int'(arr_in_a[n*W +: W]) : int'(arr_in_b[(n-2)*W +: W]);
            if (v != 0) begin
                chk($sformatf("lane%0d data expected", n), int'(lq[n].size() > 0), 1);
                if (lq[n].size() > 0) begin
                    e = lq[n].pop_front();
                    chk($sformatf("lane%0d cycle", n), cyc, e.cyc);
                    chk($sformatf("lane%0d value", n), v, e.v0);
                end
            end
        end
        if (busy && !busy_prev) bstart = cyc;
        if (!busy && busy_prev) begin
            chk("busy window expected", int'(busy_q.size() > 0), 1);
            if (busy_q.size() > 0) begin
                e = busy_q.pop_front();
                chk("busy rise cycle", bstart, e.cyc);
                chk("busy length", cyc - bstart, e.v0);
            end
        end
        busy_prev = busy;
        if (done || c_valid) begin
            chk("done expected", int'(done_q.size() > 0), 1);
            chk("done/c_valid paired", int'(done), int'(c_valid));
            if (done_q.size() > 0) begin
                e = done_q.pop_front();
                chk("done cycle", cyc, e.cyc);
                chk("SIMD_Control at done", int'(SIMD_Control), e.v0);
            end
        end
        if (c_valid4) begin
            chk("dut4 done with c_valid", int'(done4), 1);
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    chk("tile expected", int'(cq.size() > 0), 1);
                    if (cq.size() > 0) begin
                        e = cq.pop_front();
                        chk("tile cycle", cyc, e.cyc);
                        chk($sformatf("out_c[%0d][%0d]", r, c), acc[r][c], e.v1);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, " a_rd_en"}, int'(a_rd_en), 0);
        chk({tag, " b_rd_en"}, int'(b_rd_en), 0);
        chk({tag, " a_rd_addr"}, int'(a_rd_addr), 0);
        chk({tag, " b_rd_addr"}, int'(b_rd_addr), 0);
        chk({tag, " arr_in_a"}, int'(arr_in_a != 0), 0);
        chk({tag, " arr_in_b"}, int'(arr_in_b != 0), 0);
        chk({tag, " SIMD_Control"}, int'(SIMD_Control), 0);
        chk({tag, " arr_clear"}, int'(arr_clear), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " c_valid"}, int'(c_valid), 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || busy4) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("idle within budget", int'(busy || busy4), 0);
    endtask

    task automatic issue_job(input int k, input int ab, input int bb, input int md);
        int s;
        @(negedge clk);
        start = 1'b1; k_len = 8'(k); a_base = 10'(ab); b_base = 10'(bb); simd_mode = 2'(md);
        s = cyc;
        push_exp(s, k, ab, bb, md);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        reset = 1'b0;
        start = 1'b0; k_len = '0; a_base = '0; b_base = '0; simd_mode = '0;
        start4 = 1'b0; k_len4 = '0; a_base4 = '0; b_base4 = '0; simd_mode4 = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        chk("reset dut4 busy", int'(busy4), 0);
        chk("reset dut4 arr_in", int'(arr_in_a4 != 0 || arr_in_b4 != 0), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // nominal job, zero-length job, address wrap
        issue_job(3, 5, 9, 2);
        issue_job(0, 77, 88, 3);
        issue_job(2, 1023, 1022, 1);

        // start held high: accepted at s and s+12 only; mid-job input changes ignored
        @(negedge clk);
        start = 1'b1; k_len = 8'd3; a_base = 10'd5; b_base = 10'd9; simd_mode = 2'd1;
        s = cyc;
        push_exp(s, 3, 5, 9, 1);
        repeat (5) @(negedge clk);
        k_len = 8'd2; a_base = 10'd100; b_base = 10'd200; simd_mode = 2'd2;
        push_exp(s + 12, 2, 100, 200, 2);
        while (cyc < s + 13) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset in FEED cycle 3: only clear, first read and a 2-cycle busy window occur
        @(negedge clk);
        start = 1'b1; k_len = 8'd5; a_base = 10'd40; b_base = 10'd60; simd_mode = 2'd3;
        s = cyc;
        clr_q.push_back(ev_t'{s + 1, 0, 0});
        addr_q.push_back(ev_t'{s + 2, 40, 60});
        busy_q.push_back(ev_t'{s + 1, 2, 0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_outputs_zero("async reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue_job(2, 300, 400, 1);

        // identity tile on the 4x4 instance: out_c must equal B
        @(negedge clk);
        start4 = 1'b1; k_len4 = 8'd4; a_base4 = 10'd0; b_base4 = 10'd20; simd_mode4 = 2'd1;
        s = cyc;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                cq.push_back(ev_t'{s + 16, r * 4 + c, 16 * (r + 1) + c + 1});
        @(negedge clk);
        start4 = 1'b0;
        wait_idle();

        repeat (4) @(negedge clk);
        chk("SIMD_Control holds in IDLE", int'(SIMD_Control), 1);
        chk("dut4 SIMD_Control", int'(SIMD_Control4), 1);
        chk("leftover clear events", clr_q.size(), 0);
        chk("leftover read events", addr_q.size(), 0);
        chk("leftover done events", done_q.size(), 0);
        chk("leftover busy events", busy_q.size(), 0);
        chk("leftover tile entries", cq.size(), 0);
        for (int n = 0; n < 4; n++) chk($sformatf("leftover lane%0d events", n), lq[n].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // absolute guard against a hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sys_array_sched.md
# sys_array_sched

Sequencing controller for the aligned systolic-array datapath. It accepts one matrix-tile job per start pulse, streams K operand vectors from the A (row-operand) and B (column-operand) buffers, and applies the diagonal input skew the array requires. It then waits for the array pipeline to drain and flags the moment the array's result bus holds the finished tile.

## Interface
- ROWS, 4: total A lanes (array height in PEs).
- COLS, 256: total B lanes (array width in PEs).
- WIDTH, 16: element width.
- K_W, 8: width of the job depth field.
- ADDR_W, 10: operand-buffer address width.
- DRAIN_PAD, 2: extra drain cycles beyond ROWS+COLS.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  K_W  vectors to stream; sampled with start.
- a_base, b_base  in  ADDR_W  first buffer addresses; sampled with start.
- simd_mode  in  2  precision mode; sampled with start.
- a_rd_data  in  ROWS*WIDTH  A buffer read data, valid 1 cycle after a_rd_en.
- b_rd_data  in  COLS*WIDTH  B buffer read data, valid 1 cycle after b_rd_en.
- a_rd_en, b_rd_en  out  1  buffer read strobes.
- a_rd_addr, b_rd_addr  out  ADDR_W  buffer read addresses.
- arr_in_a  out  ROWS*WIDTH  skewed A stream to the array.
- arr_in_b  out  COLS*WIDTH  skewed B stream to the array.
- SIMD_Control  out  2  array mode, held for the whole job.
- arr_clear  out  1  one-cycle accumulator clear to the array.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- c_valid  out  1  array out_c holds the final tile; coincides with done.

## Operation
- The FSM has five states: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE**
  - On start=1: latch k_len, a_base, b_base and simd_mode; go to CLEAR.
  - start in any other state is ignored and not queued.
- **CLEAR**
  - One cycle with arr_clear=1.
  - Next state is FEED when k_len≠0, otherwise DONE.
- **FEED**
  - Lasts exactly k_len cycles with a_rd_en=b_rd_en=1.
  - Addresses are base+i for i=0..k_len-1, wrapping modulo 2^ADDR_W.
- **DRAIN**
  - Lasts exactly ROWS+COLS+DRAIN_PAD cycles.
  - Read strobes are 0 throughout.
- **DONE**
  - One cycle with done=1 and c_valid=1; then IDLE.
- busy=1 in CLEAR, FEED, DRAIN and DONE; busy=0 in IDLE.
- SIMD_Control is registered from the latched simd_mode on entry to CLEAR. It holds until the next accepted start and is not cleared in IDLE.
- **Skew**
  - Read data is tagged valid one cycle after a strobe.
  - A lane r passes through r register stages; B lane c passes through c stages.
  - A lane with no valid data at a stage carries zero, so the array sees zeros outside the data diagonal.
- k_len=0 means no reads take place and DRAIN is skipped. done and c_valid still pulse, and the tile is the cleared (zero) result.

## Timing
- Cycle 0: IDLE samples start=1.
- Cycle 1: CLEAR (arr_clear=1).
- Cycles 2..k_len+1: FEED; address base+i appears in cycle 2+i.
- Read data for index i reaches arr_in_a/arr_in_b lane 0 in cycle 3+i and lane n in cycle 3+i+n.
- Cycles k_len+2 .. k_len+1+ROWS+COLS+DRAIN_PAD: DRAIN.
- DONE in cycle k_len+2+ROWS+COLS+DRAIN_PAD. Total latency from start to done is k_len+ROWS+COLS+DRAIN_PAD+2 cycles.
- The earliest next start is sampled in the cycle after DONE, which gives back-to-back jobs with one IDLE cycle between them.
- Reset values:
  - All outputs 0.
  - SIMD_Control=0.
  - All skew registers 0.
  - FSM in IDLE.
- Reset mid-job aborts the job immediately. No done pulse is produced, and the first job after deassertion starts from a clean state.

## Test plan
- Bench settings: ROWS=2, COLS=2, DRAIN_PAD=2.
  - start with k_len=3, a_base=5, b_base=9 → arr_clear in cycle 1; a_rd_addr 5,6,7 and b_rd_addr 9,10,11 in cycles 2–4; done in cycle 11; busy high in cycles 1–11.
  - Skew: A buffer returns lane0=1 and lane1=2 per read → arr_in_a lane0 nonzero in cycles 3–5, lane1 nonzero in cycles 4–6, zero in all other cycles; B behaves the same way.
- Bench settings: ROWS=4, COLS=4, full array model.
  - Identity A and a known B with k_len=4 → out_c equals B when c_valid=1.
- Back-to-back and ignored starts: start held high continuously → a job is accepted at cycles 0 and 12 only; k_len/simd_mode changes while busy do not affect the running job.
- Boundary cases:
  - k_len=0 → CLEAR in cycle 1, done and c_valid in cycle 2, no read strobes.
  - a_base=1023 with k_len=2 → addresses 1023 then 0.
- Reset during FEED (cycle 3) → all outputs 0 asynchronously with no done pulse; a new start after release runs with full timing.
